// File: rtl/dvfs_pkg.sv
// Shared types and helpers for the multi-domain DVFS controller.
package dvfs_pkg;
  localparam int LVL_W = 3;

  typedef logic [LVL_W-1:0] level_t;

  typedef enum logic [2:0] {
    S_IDLE, S_V_REQ, S_V_SETTLE, S_F_SET, S_F_SETTLE, S_GATED, S_WAKE
  } dvfs_state_e;

  function automatic level_t level_min(level_t a, level_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic level_t level_max(level_t a, level_t b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/dvfs_domain_fsm.sv
// Per-domain V/F sequencer: hysteresis, limit clamping, regulator handshake and idle gating.
module dvfs_domain_fsm
  import dvfs_pkg::*;
#(
  parameter int LOAD_WIDTH         = 16,
  parameter int DEFAULT_LEVEL      = 4,
  parameter int HYST_COUNT         = 4,
  parameter int VOLT_SETTLE_CYCLES = 32,
  parameter int FREQ_SETTLE_CYCLES = 8,
  parameter int GATE_IDLE_CYCLES   = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  tick_i,
  input  logic [LOAD_WIDTH-1:0] load_i,
  input  logic                  active_i,
  input  logic [LOAD_WIDTH-1:0] up_thr_i,
  input  logic [LOAD_WIDTH-1:0] dn_thr_i,
  input  level_t                eff_min_i,
  input  level_t                eff_max_i,
  input  logic                  vreg_ack_i,
  output level_t                volt_o,
  output level_t                freq_o,
  output logic                  vreg_req_o,
  output level_t                vreg_tgt_o,
  output logic                  gate_o,
  output logic                  busy_o
);
  localparam int SMAX = (VOLT_SETTLE_CYCLES > FREQ_SETTLE_CYCLES) ? VOLT_SETTLE_CYCLES
                                                                  : FREQ_SETTLE_CYCLES;
  localparam int CW = $clog2(SMAX + 1);
  localparam int IW = $clog2(GATE_IDLE_CYCLES + 1);
  localparam int HW = $clog2(HYST_COUNT + 1);
  localparam logic [HW-1:0] HMAX = HW'(HYST_COUNT);

  dvfs_state_e     state_q, state_d;
  level_t          volt_q, volt_d, freq_q, freq_d, tgt_q, tgt_d;
  logic            dir_up_q, dir_up_d;
  logic [HW-1:0]   up_q, up_d, dn_q, dn_d, up_nx, dn_nx;
  logic [IW-1:0]   idle_q, idle_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            go_up, go_dn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      volt_q   <= level_t'(DEFAULT_LEVEL);
      freq_q   <= level_t'(DEFAULT_LEVEL);
      tgt_q    <= level_t'(DEFAULT_LEVEL);
      dir_up_q <= 1'b0;
      up_q     <= '0;
      dn_q     <= '0;
      idle_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      volt_q   <= volt_d;
      freq_q   <= freq_d;
      tgt_q    <= tgt_d;
      dir_up_q <= dir_up_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      idle_q   <= idle_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    volt_d   = volt_q;
    freq_d   = freq_q;
    tgt_d    = tgt_q;
    dir_up_d = dir_up_q;
    up_d     = up_q;
    dn_d     = dn_q;
    idle_d   = idle_q;
    cnt_d    = cnt_q;
    up_nx    = up_q;
    dn_nx    = dn_q;
    go_up    = 1'b0;
    go_dn    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!en_i) begin
          up_d   = '0;
          dn_d   = '0;
          idle_d = '0;
        end else if (volt_q > eff_max_i) begin
          go_dn = 1'b1;
        end else if (volt_q < eff_min_i) begin
          go_up = 1'b1;
        end else begin
          if (tick_i) begin
            if (load_i > up_thr_i) begin
              up_nx = (up_q == HMAX) ? up_q : up_q + HW'(1);
              dn_nx = '0;
            end else if (load_i < dn_thr_i) begin
              dn_nx = (dn_q == HMAX) ? dn_q : dn_q + HW'(1);
              up_nx = '0;
            end else begin
              up_nx = '0;
              dn_nx = '0;
            end
            up_d  = up_nx;
            dn_d  = dn_nx;
            go_up = (up_nx == HMAX) && (volt_q < eff_max_i);
            go_dn = !go_up && (dn_nx == HMAX) && (volt_q > eff_min_i);
          end
          if (!go_up && !go_dn) begin
            if (!active_i && (load_i == '0)) begin
              if (idle_q == IW'(GATE_IDLE_CYCLES - 1)) begin
                state_d = S_GATED;
                idle_d  = '0;
                up_d    = '0;
                dn_d    = '0;
              end else begin
                idle_d = idle_q + IW'(1);
              end
            end else begin
              idle_d = '0;
            end
          end
        end
        // Up raises voltage first; down lowers frequency first.
        if (go_up) begin
          state_d  = S_V_REQ;
          tgt_d    = volt_q + level_t'(1);
          dir_up_d = 1'b1;
          up_d     = '0;
          dn_d     = '0;
          idle_d   = '0;
        end else if (go_dn) begin
          state_d  = S_F_SET;
          tgt_d    = volt_q - level_t'(1);
          dir_up_d = 1'b0;
          up_d     = '0;
          dn_d     = '0;
          idle_d   = '0;
        end
      end
      S_V_REQ: begin
        if (vreg_ack_i) begin
          volt_d  = tgt_q;
          cnt_d   = '0;
          state_d = S_V_SETTLE;
        end
      end
      S_V_SETTLE: begin
        if (cnt_q == CW'(VOLT_SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = dir_up_q ? S_F_SET : S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_F_SET: begin
        freq_d  = tgt_q;
        cnt_d   = '0;
        state_d = S_F_SETTLE;
      end
      S_F_SETTLE: begin
        if (cnt_q == CW'(FREQ_SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = dir_up_q ? S_IDLE : S_V_REQ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GATED: begin
        cnt_d = '0;
        if (active_i || !en_i) state_d = S_WAKE;
      end
      S_WAKE: begin
        if (cnt_q == CW'(VOLT_SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    volt_o     = volt_q;
    freq_o     = freq_q;
    vreg_tgt_o = tgt_q;
    vreg_req_o = (state_q == S_V_REQ);
    gate_o     = (state_q == S_GATED);
    busy_o     = (state_q != S_IDLE) && (state_q != S_GATED);
  end
endmodule

// File: rtl/dvfs_domain_controller.sv
// Multi-domain DVFS controller: shared eval tick and limit resolution, one sequencer per domain.
module dvfs_domain_controller
  import dvfs_pkg::*;
#(
  parameter int NUM_DOMAINS        = 4,
  parameter int LOAD_WIDTH         = 16,
  parameter int LEVEL_WIDTH        = LVL_W,
  parameter int DEFAULT_LEVEL      = 4,
  parameter int EVAL_PERIOD        = 64,
  parameter int HYST_COUNT         = 4,
  parameter int VOLT_SETTLE_CYCLES = 32,
  parameter int FREQ_SETTLE_CYCLES = 8,
  parameter int GATE_IDLE_CYCLES   = 128
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               dvfs_enable,
  input  logic [NUM_DOMAINS*LOAD_WIDTH-1:0]  domain_load,
  input  logic [NUM_DOMAINS-1:0]             domain_active,
  input  logic [LOAD_WIDTH-1:0]              up_threshold,
  input  logic [LOAD_WIDTH-1:0]              down_threshold,
  input  logic [LEVEL_WIDTH-1:0]             min_level,
  input  logic [LEVEL_WIDTH-1:0]             max_level,
  input  logic                               thermal_alert,
  input  logic [LEVEL_WIDTH-1:0]             thermal_cap_level,
  output logic [NUM_DOMAINS*LEVEL_WIDTH-1:0] volt_level,
  output logic [NUM_DOMAINS*LEVEL_WIDTH-1:0] freq_level,
  output logic [NUM_DOMAINS-1:0]             vreg_req,
  output logic [NUM_DOMAINS*LEVEL_WIDTH-1:0] vreg_target,
  input  logic [NUM_DOMAINS-1:0]             vreg_ack,
  output logic [NUM_DOMAINS-1:0]             domain_power_gate,
  output logic [NUM_DOMAINS-1:0]             transition_busy
);
  localparam int TW = (EVAL_PERIOD > 1) ? $clog2(EVAL_PERIOD) : 1;

  logic [TW-1:0] timer_q, timer_d;
  logic          tick;
  level_t        eff_max, eff_min;

  assign tick    = (timer_q == TW'(EVAL_PERIOD - 1));
  assign timer_d = tick ? '0 : timer_q + TW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end

  // Thermal ceiling dominates the floor so the cap is always honoured.
  assign eff_max = level_min(max_level, thermal_alert ? thermal_cap_level : '1);
  assign eff_min = level_min(min_level, eff_max);

  for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
    dvfs_domain_fsm #(
      .LOAD_WIDTH        (LOAD_WIDTH),
      .DEFAULT_LEVEL     (DEFAULT_LEVEL),
      .HYST_COUNT        (HYST_COUNT),
      .VOLT_SETTLE_CYCLES(VOLT_SETTLE_CYCLES),
      .FREQ_SETTLE_CYCLES(FREQ_SETTLE_CYCLES),
      .GATE_IDLE_CYCLES  (GATE_IDLE_CYCLES)
    ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .en_i      (dvfs_enable),
      .tick_i    (tick),
      .load_i    (domain_load[g*LOAD_WIDTH +: LOAD_WIDTH]),
      .active_i  (domain_active[g]),
      .up_thr_i  (up_threshold),
      .dn_thr_i  (down_threshold),
      .eff_min_i (eff_min),
      .eff_max_i (eff_max),
      .vreg_ack_i(vreg_ack[g]),
      .volt_o    (volt_level[g*LEVEL_WIDTH +: LEVEL_WIDTH]),
      .freq_o    (freq_level[g*LEVEL_WIDTH +: LEVEL_WIDTH]),
      .vreg_req_o(vreg_req[g]),
      .vreg_tgt_o(vreg_target[g*LEVEL_WIDTH +: LEVEL_WIDTH]),
      .gate_o    (domain_power_gate[g]),
      .busy_o    (transition_busy[g])
    );
  end
endmodule

// File: tb/tb_dvfs_domain_controller.sv
// Directed bench for dvfs_domain_controller: hand-written sequences plus a limit-vector table.
module tb_dvfs_domain_controller;
  localparam int ND = 4;
  localparam int LW = 16;
  localparam int LV = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              dvfs_enable;
  logic [ND*LW-1:0]  domain_load;
  logic [ND-1:0]     domain_active;
  logic [LW-1:0]     up_threshold, down_threshold;
  logic [LV-1:0]     min_level, max_level, thermal_cap_level;
  logic              thermal_alert;
  logic [ND*LV-1:0]  volt_level, freq_level, vreg_target;
  logic [ND-1:0]     vreg_req, vreg_ack, domain_power_gate, transition_busy;
  logic [ND-1:0]     ack_auto = '0;
  logic [ND-1:0]     ack_spur = '0;
  bit                auto_ack = 1'b1;
  int                ack_cnt [ND];
  int                total = 0, bad = 0, inv_bad = 0;

  typedef struct {
    logic          alert;
    logic [LV-1:0] cap, mn, mx, exp;
  } vec_t;
  vec_t tbl [7];

  assign vreg_ack = ack_auto | ack_spur;

  dvfs_domain_controller dut (
    .clk(clk), .rst(rst), .dvfs_enable(dvfs_enable), .domain_load(domain_load),
    .domain_active(domain_active), .up_threshold(up_threshold),
    .down_threshold(down_threshold), .min_level(min_level), .max_level(max_level),
    .thermal_alert(thermal_alert), .thermal_cap_level(thermal_cap_level),
    .volt_level(volt_level), .freq_level(freq_level), .vreg_req(vreg_req),
    .vreg_target(vreg_target), .vreg_ack(vreg_ack),
    .domain_power_gate(domain_power_gate), .transition_busy(transition_busy)
  );

  always #5 clk = ~clk;

  function automatic int vl(int d); return int'(volt_level[d*LV +: LV]); endfunction
  function automatic int fl(int d); return int'(freq_level[d*LV +: LV]); endfunction
  function automatic int tg(int d); return int'(vreg_target[d*LV +: LV]); endfunction
  function automatic int rep(int l);
    logic [LV-1:0] x;
    x = LV'(l);
    return int'({ND{x}});
  endfunction

  task automatic set_load(int d, logic [LW-1:0] v);
    domain_load[d*LW +: LW] = v;
  endtask

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(string nm, int act, int lo, int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic wait_all(int lvl, int lim);
    int n = 0;
    while (!(int'(volt_level) == rep(lvl) && int'(freq_level) == rep(lvl) &&
             transition_busy == '0) && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Regulator model: acknowledges each request on the third negedge after it is seen.
  initial begin
    foreach (ack_cnt[d]) ack_cnt[d] = 0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        if (rst || !auto_ack) begin
          ack_cnt[d] = 0;
          ack_auto[d] = 1'b0;
        end else if (ack_auto[d]) begin
          ack_auto[d] = 1'b0;
        end else if (vreg_req[d]) begin
          if (ack_cnt[d] == 2) begin
            ack_auto[d] = 1'b1;
            ack_cnt[d] = 0;
          end else begin
            ack_cnt[d]++;
          end
        end else begin
          ack_cnt[d] = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst)
        for (int d = 0; d < ND; d++)
          if (fl(d) > vl(d)) inv_bad++;
    end
  end

  initial begin
    int n, steps, prev;
    tbl[0] = '{1'b1, 3'd1, 3'd3, 3'd5, 3'd1};
    tbl[1] = '{1'b0, 3'd1, 3'd4, 3'd7, 3'd4};
    tbl[2] = '{1'b0, 3'd1, 3'd0, 3'd2, 3'd2};
    tbl[3] = '{1'b0, 3'd1, 3'd7, 3'd7, 3'd7};
    tbl[4] = '{1'b1, 3'd6, 3'd7, 3'd7, 3'd6};
    tbl[5] = '{1'b0, 3'd6, 3'd5, 3'd0, 3'd0};
    tbl[6] = '{1'b0, 3'd6, 3'd0, 3'd7, 3'd0};

    dvfs_enable = 1'b1;  thermal_alert = 1'b0;  thermal_cap_level = 3'd7;
    min_level = 3'd0;    max_level = 3'd7;
    up_threshold = 16'hA000;  down_threshold = 16'h4000;
    domain_active = '1;
    for (int d = 0; d < ND; d++) set_load(d, 16'h8000);

    repeat (2) @(negedge clk);
    chk("rst_volt", int'(volt_level), rep(4));
    chk("rst_freq", int'(freq_level), rep(4));
    chk("rst_target", int'(vreg_target), rep(4));
    chk("rst_req", int'(vreg_req), 0);
    chk("rst_busy", int'(transition_busy), 0);
    chk("rst_gate", int'(domain_power_gate), 0);
    rst = 1'b0;

    // Step up on domain 0 through four ticks of high load.
    @(negedge clk);
    set_load(0, 16'hC000);
    n = 0;
    while (!vreg_req[0] && n < 400) begin @(negedge clk); n++; end
    chk_rng("up_req_delay", n, 190, 260);
    chk("up_target", tg(0), 5);
    chk("up_volt_before_ack", vl(0), 4);
    n = 0;
    while (vl(0) != 5 && n < 20) begin @(negedge clk); n++; end
    chk_rng("up_req_to_volt", n, 2, 5);
    chk("up_freq_lags", fl(0), 4);
    n = 0;
    while (fl(0) != 5 && n < 60) begin @(negedge clk); n++; end
    chk_rng("up_vsettle", n, 32, 34);
    set_load(0, 16'h8000);
    chk("up_others_hold", int'(volt_level[ND*LV-1:LV]), rep(4) >> LV);
    n = 0;
    while (transition_busy[0] && n < 20) begin @(negedge clk); n++; end
    chk("up_done", int'(transition_busy[0]), 0);

    // Step down on domain 1: frequency moves before voltage.
    set_load(1, 16'h2000);
    n = 0;
    while (fl(1) != 3 && n < 400) begin @(negedge clk); n++; end
    chk("dn_freq_first", fl(1), 3);
    chk("dn_volt_held", vl(1), 4);
    n = 0;
    while (!vreg_req[1] && n < 20) begin @(negedge clk); n++; end
    chk_rng("dn_fsettle", n, 7, 9);
    chk("dn_target", tg(1), 3);
    n = 0;
    while (vl(1) != 3 && n < 20) begin @(negedge clk); n++; end
    chk("dn_volt", vl(1), 3);
    set_load(1, 16'h8000);

    // Floor clamp lifts everything to 6 without waiting for ticks.
    min_level = 3'd6;
    wait_all(6, 500);
    chk("clamp_min_all6", int'(volt_level), rep(6));

    // Thermal cap: 6->5->4->3->2 single steps, no up-step while capped.
    min_level = 3'd0;
    set_load(0, 16'hF000);
    thermal_cap_level = 3'd2;
    thermal_alert = 1'b1;
    n = 0; steps = 0; prev = vl(0);
    while (vl(0) != 2 && n < 260) begin
      @(negedge clk);
      n++;
      if (vl(0) != prev) begin
        steps += (vl(0) == prev - 1) ? 1 : 100;
        prev = vl(0);
      end
    end
    chk_rng("therm_fast", n, 120, 240);
    chk("therm_single_steps", steps, 4);
    repeat (600) @(negedge clk);
    chk("therm_cap_hold", vl(0), 2);
    chk("therm_all", int'(volt_level), rep(2));

    // Limits: min 3, max 5, domain 0 under heavy load tops out at 5.
    thermal_alert = 1'b0;
    min_level = 3'd3;
    max_level = 3'd5;
    n = 0;
    while (!(vl(0) == 5 && !transition_busy[0]) && n < 1200) begin @(negedge clk); n++; end
    chk("lim_reach5", vl(0), 5);
    repeat (400) @(negedge clk);
    chk("lim_stop5", vl(0), 5);
    chk("lim_others3", int'(volt_level[ND*LV-1:LV]), rep(3) >> LV);

    // Idle gating on domain 2, then wake.
    set_load(2, 16'h0000);
    domain_active[2] = 1'b0;
    n = 0;
    while (!domain_power_gate[2] && n < 200) begin @(negedge clk); n++; end
    chk_rng("gate_delay", n, 127, 130);
    chk("gate_busy", int'(transition_busy[2]), 0);
    chk("gate_volt_hold", vl(2), 3);
    repeat (5) @(negedge clk);
    domain_active[2] = 1'b1;
    set_load(2, 16'h8000);
    @(negedge clk);
    chk("wake_gate_off", int'(domain_power_gate[2]), 0);
    chk("wake_busy", int'(transition_busy[2]), 1);
    n = 0;
    while (transition_busy[2] && n < 100) begin n++; @(negedge clk); end
    chk_rng("wake_len", n, 31, 33);
    set_load(0, 16'h8000);

    for (int i = 0; i < 7; i++) begin
      thermal_alert = tbl[i].alert;
      thermal_cap_level = tbl[i].cap;
      min_level = tbl[i].mn;
      max_level = tbl[i].mx;
      repeat (400) @(negedge clk);
      chk($sformatf("tbl%0d_volt", i), int'(volt_level), rep(int'(tbl[i].exp)));
      chk($sformatf("tbl%0d_freq", i), int'(freq_level), rep(int'(tbl[i].exp)));
      chk($sformatf("tbl%0d_busy", i), int'(transition_busy), 0);
    end

    // Global disable freezes levels even against the floor and high load.
    dvfs_enable = 1'b0;
    min_level = 3'd3;
    set_load(0, 16'hF000);
    repeat (300) @(negedge clk);
    chk("en_off_hold", int'(volt_level), 0);
    chk("en_off_busy", int'(transition_busy), 0);
    dvfs_enable = 1'b1;
    set_load(0, 16'h8000);
    wait_all(3, 400);
    chk("en_on_clamp", int'(volt_level), rep(3));

    // Ack without a request is ignored.
    auto_ack = 1'b0;
    @(negedge clk);
    ack_spur[3] = 1'b1;
    @(negedge clk);
    ack_spur[3] = 1'b0;
    repeat (3) @(negedge clk);
    chk("spur_ack_volt", vl(3), 3);
    chk("spur_ack_busy", int'(transition_busy[3]), 0);

    // Requests hold without ack; async reset clears them immediately.
    min_level = 3'd4;
    n = 0;
    while (vreg_req != '1 && n < 10) begin @(negedge clk); n++; end
    chk("rmid_req", int'(vreg_req), 15);
    repeat (10) @(negedge clk);
    chk("rmid_hold_req", int'(vreg_req), 15);
    chk("rmid_hold_tgt", int'(vreg_target), rep(4));
    chk("rmid_busy", int'(transition_busy), 15);
    #2 rst = 1'b1;
    #1;
    chk("rmid_req_drop", int'(vreg_req), 0);
    chk("rmid_volt", int'(volt_level), rep(4));
    chk("rmid_busy_clr", int'(transition_busy), 0);
    @(negedge clk);
    rst = 1'b0;
    auto_ack = 1'b1;
    repeat (200) @(negedge clk);
    chk("rmid_after", int'(volt_level), rep(4));
    chk("rmid_after_busy", int'(transition_busy), 0);

    chk("inv_freq_le_volt", inv_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
